keypad_event_ctrl: RTL and testbench

KEYPAD_EVENT_CTRL -- requirements
Module: keypad_event_ctrl

---
 rtl/keypad_event_ctrl.sv | 164 ++++++++++++++++
 tb/tb_keypad_event_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_ctrl.sv
// +----------------------------------------------------------------------------
// | keypad_event_ctrl : debounces a 16-key vector and queues one key code per
// | press into a 4-entry FIFO, with sticky overflow and multi-key flags.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module keypad_event_ctrl #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] key,
  input  logic        pop,
  input  logic        clr,
  output logic [3:0]  code,
  output logic        valid,
  output logic [2:0]  count,
  output logic        overflow,
  output logic        multi
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_STABLE  = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] DEB_MAX = 8'(DEB_CYCLES);

  state_t      state;
  logic [15:0] key_q;
  logic [7:0]  stab_cnt;
  logic [3:0]  press_idx;
  logic [3:0]  mem [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;

  logic        stable;
  logic [4:0]  ones;
  logic [3:0]  enc_idx;
  logic        one_key;
  logic        chord;
  logic        push_en;
  logic        do_pop;
  logic        do_push;
  logic        full;

  assign stable = (stab_cnt == DEB_MAX);

  always_comb begin
    ones    = 5'd0;
    enc_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (key_q[i]) begin
        ones    = ones + 5'd1;
        enc_idx = 4'(i);
      end
    end
  end

  assign one_key = (ones == 5'd1);
  assign chord   = (ones > 5'd1);
  assign push_en = (state == WAIT_STABLE) && stable && one_key;

  // Debounce: the counter measures how long key_q has matched the raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '0;
      stab_cnt <= '0;
    end else if (clr) begin
      key_q    <= '0;
      stab_cnt <= '0;
    end else begin
      key_q <= key;
      if (key != key_q)
        stab_cnt <= '0;
      else if (stab_cnt != DEB_MAX)
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      press_idx <= '0;
      multi     <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      press_idx <= '0;
      multi     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_q != '0)
            state <= WAIT_STABLE;
        end
        WAIT_STABLE: begin
          if (key_q == '0) begin
            state <= IDLE;
          end else if (stable && one_key) begin
            press_idx <= enc_idx;
            state     <= PRESSED;
          end else if (stable && chord) begin
            multi <= 1'b1;
            state <= WAIT_RELEASE;
          end
        end
        PRESSED: begin
          // A brief bounce to zero and back to the same key is not a new press.
          if (stable && key_q == '0)
            state <= IDLE;
          else if (key_q != '0 && key_q != (16'h0001 << press_idx))
            state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (stable && key_q == '0)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full    = (count == 3'd4);
  assign do_pop  = pop && (count != 3'd0);
  assign do_push = push_en && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= enc_idx;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 2'd1;
      if (do_push && !do_pop)
        count <= count + 3'd1;
      else if (do_pop && !do_push)
        count <= count - 3'd1;
      if (push_en && full && !do_pop)
        overflow <= 1'b1;
    end
  end

  assign valid = (count != 3'd0);
  assign code  = valid ? mem[rd_ptr] : 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_keypad_event_ctrl.sv
// +----------------------------------------------------------------------------
// | tb_keypad_event_ctrl : vector table plus directed sequences for keypad_event_ctrl
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_keypad_event_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] key = '0;
  logic        pop = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  code;
  logic        valid;
  logic [2:0]  count;
  logic        overflow;
  logic        multi;

  keypad_event_ctrl #(.DEB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .pop(pop), .clr(clr),
    .code(code), .valid(valid), .count(count), .overflow(overflow), .multi(multi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] key;
    logic        exp_push;
    logic [3:0]  exp_code;
    logic        exp_multi;
  } vec_t;

  vec_t       vecs [7];
  logic [3:0] exp_q [$];
  logic       exp_ovf;
  logic       exp_multi;
  int         tests = 0;
  int         fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [3:0] c);
    if (exp_q.size() < 4) exp_q.push_back(c);
    else exp_ovf = 1'b1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    exp_ovf   = 1'b0;
    exp_multi = 1'b0;
  endtask

  task automatic press(input logic [15:0] k, input int hold, input int rel);
    key = k;
    ticks(hold);
    key = '0;
    ticks(rel);
  endtask

  task automatic check_state(input string name);
    check({name, ".count"}, 32'(count), 32'(exp_q.size()));
    check({name, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    check({name, ".multi"}, 32'(multi), 32'(exp_multi));
  endtask

  // Compare the head against the scoreboard, then consume it.
  task automatic pop_check(input string name);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      check({name, ".empty_valid"}, 32'(valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({name, ".valid"}, 32'(valid), 32'd1);
      check({name, ".code"}, 32'(code), 32'(e));
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{key: 16'h0020, exp_push: 1'b1, exp_code: 4'd5,  exp_multi: 1'b0};
    vecs[1] = '{key: 16'h0001, exp_push: 1'b1, exp_code: 4'd0,  exp_multi: 1'b0};
    vecs[2] = '{key: 16'h8000, exp_push: 1'b1, exp_code: 4'd15, exp_multi: 1'b0};
    vecs[3] = '{key: 16'h0041, exp_push: 1'b0, exp_code: 4'd0,  exp_multi: 1'b1};
    vecs[4] = '{key: 16'h0300, exp_push: 1'b0, exp_code: 4'd0,  exp_multi: 1'b1};
    vecs[5] = '{key: 16'h0000, exp_push: 1'b0, exp_code: 4'd0,  exp_multi: 1'b0};
    vecs[6] = '{key: 16'h0400, exp_push: 1'b1, exp_code: 4'd10, exp_multi: 1'b0};
    exp_ovf   = 1'b0;
    exp_multi = 1'b0;

    // Reset state
    ticks(2);
    check("rst.valid", 32'(valid), 32'd0);
    check("rst.count", 32'(count), 32'd0);
    check("rst.code", 32'(code), 32'd0);
    check("rst.overflow", 32'(overflow), 32'd0);
    check("rst.multi", 32'(multi), 32'd0);
    rst_n = 1'b1;
    ticks(2);

    // Vector table: one press per record, each from a cleared block
    for (int v = 0; v < 7; v++) begin
      do_clr();
      press(vecs[v].key, 10, 10);
      if (vecs[v].exp_push) model_push(vecs[v].exp_code);
      if (vecs[v].exp_multi) exp_multi = 1'b1;
      check_state($sformatf("vec%0d", v));
      pop_check($sformatf("vec%0d.pop", v));
      pop_check($sformatf("vec%0d.after", v));
    end

    // Single press held 10 cycles: one push, no repeat, none on release
    do_clr();
    key = 16'h0020;
    ticks(10);
    model_push(4'd5);
    check("hold.count", 32'(count), 32'd1);
    check("hold.code", 32'(code), 32'd5);
    check("hold.valid", 32'(valid), 32'd1);
    key = '0;
    ticks(10);
    check_state("hold.release");
    pop_check("hold.pop");
    pop_check("hold.empty");

    // Bouncing key never stabilises
    do_clr();
    for (int i = 0; i < 10; i++) begin
      key = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      ticks(2);
    end
    key = '0;
    ticks(10);
    check_state("bounce");

    // Chord then partial release, then a clean press
    do_clr();
    key = 16'h0041;
    ticks(10);
    exp_multi = 1'b1;
    check_state("chord");
    key = 16'h0040;
    ticks(10);
    check_state("chord.partial");
    key = '0;
    ticks(10);
    check_state("chord.released");
    press(16'h0040, 10, 10);
    model_push(4'd6);
    check_state("chord.repress");
    pop_check("chord.pop");

    // Five presses without pop: overflow on the fifth
    do_clr();
    for (int i = 0; i < 5; i++) begin
      press(16'h0001 << i, 8, 8);
      model_push(4'(i));
    end
    check_state("ovf");
    check("ovf.code", 32'(code), 32'd0);
    for (int i = 0; i < 5; i++) pop_check($sformatf("ovf.pop%0d", i));

    // Full FIFO with pop in the push cycle of a fifth press
    do_clr();
    for (int i = 0; i < 4; i++) begin
      press(16'h0001 << i, 8, 8);
      model_push(4'(i));
    end
    key = 16'h0200;
    ticks(5);
    check("simul.pre_count", 32'(count), 32'd4);
    check("simul.pre_code", 32'(code), 32'(exp_q.pop_front()));
    pop = 1'b1;
    tick();
    pop = 1'b0;
    model_push(4'd9);
    check("simul.count", 32'(count), 32'd4);
    check("simul.overflow", 32'(overflow), 32'd0);
    key = '0;
    ticks(10);
    check_state("simul.release");
    for (int i = 0; i < 5; i++) pop_check($sformatf("simul.pop%0d", i));

    // Asynchronous reset while a key is held in PRESSED
    do_clr();
    key = 16'h8000;
    ticks(10);
    check("arst.pre_count", 32'(count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(valid), 32'd0);
    check("arst.count", 32'(count), 32'd0);
    check("arst.code", 32'(code), 32'd0);
    check("arst.overflow", 32'(overflow), 32'd0);
    check("arst.multi", 32'(multi), 32'd0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    ticks(10);
    model_push(4'd15);
    check_state("arst.repush");
    ticks(10);
    check_state("arst.held");
    key = '0;
    ticks(10);
    pop_check("arst.pop");
    pop_check("arst.empty");

    // Clear in the same cycle as a pop
    press(16'h0008, 10, 10);
    pop = 1'b1;
    clr = 1'b1;
    tick();
    pop = 1'b0;
    clr = 1'b0;
    exp_q.delete();
    check_state("clr.prio");
    check("clr.valid", 32'(valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
